cpu_oci_dct_packer: RTL and testbench

- Upstream stage of the CPU OCI test-bench monitor.
- Packs 2-bit direct-control-transfer (DCT) codes from the retiring instruction stream into a 30-bit shift buffer with a 4-bit entry count.
- Exposes `dct_buffer`/`dct_count` live to the test-bench monitor.
- Emits completed trace frames over a valid/ready handshake to the trace-memory writer.

---
 rtl/cpu_oci_trace_pkg.sv | 37 +++
 rtl/cpu_oci_dct_packer_if.sv | 12 +
 rtl/cpu_oci_frame_slot.sv | 60 ++++++
 rtl/cpu_oci_dct_packer.sv | 110 +++++++++++
 tb/tb_cpu_oci_dct_packer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_oci_trace_pkg.sv
// Shared types and constants for the CPU OCI DCT trace packer.
// DCT_TIMESTAMP_EN widens the frame with a leading cycle timestamp.
package cpu_oci_trace_pkg;

  localparam int DEF_DCT_ENTRIES = 15;
  localparam int DEF_CODE_W      = 2;
  localparam int DEF_TS_W        = 16;

  localparam int DCT_BUF_W = DEF_DCT_ENTRIES * DEF_CODE_W;
  localparam int DCT_CNT_W = $clog2(DEF_DCT_ENTRIES + 1);

  localparam logic [1:0] FRAME_TYPE_DCT = 2'b10;

  typedef enum logic [1:0] {
    DCT_NOT_TAKEN = 2'b00,
    DCT_TAKEN     = 2'b01,
    DCT_CALL      = 2'b10,
    DCT_RETURN    = 2'b11
  } dct_code_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
`ifdef DCT_TIMESTAMP_EN
    logic [DEF_TS_W-1:0]  ts;
`endif
    logic [1:0]           ftype;
    logic [DCT_CNT_W-1:0] count;
    logic [DCT_BUF_W-1:0] buffer;
  } dct_frame_t;

  localparam int FRAME_W = $bits(dct_frame_t);

endpackage

// File: rtl/cpu_oci_dct_packer_if.sv
// Frame handshake between the DCT packer (master) and the trace-memory writer (slave).
// Frame width grows when DCT_TIMESTAMP_EN is defined.
interface cpu_oci_dct_packer_if #(
  parameter int FRAME_DW = cpu_oci_trace_pkg::FRAME_W
);
  logic                frame_valid;
  logic [FRAME_DW-1:0] frame_data;
  logic                frame_ready;

  modport master (output frame_valid, output frame_data, input frame_ready);
  modport slave  (input frame_valid, input frame_data, output frame_ready);
endinterface

// File: rtl/cpu_oci_frame_slot.sv
// Single-entry valid/ready output register; a load while full with no
// transfer in the same cycle is dropped and reported on o_drop.
module cpu_oci_frame_slot
  import cpu_oci_trace_pkg::*;
#(
  parameter int W = FRAME_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_drop
);

  slot_state_e r_state;
  slot_state_e w_next;
  logic        w_take;
  logic [W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (reset) r_state <= SLOT_EMPTY;
    else       r_state <= w_next;
  end

  // Data clears on reset so the frame bus reads zero until the first load.
  always_ff @(posedge clk) begin
    if (reset)       r_data <= '0;
    else if (w_take) r_data <= i_data;
  end

  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    o_drop = 1'b0;
    case (r_state)
      SLOT_EMPTY: begin
        if (i_load) begin
          w_next = SLOT_FULL;
          w_take = 1'b1;
        end
      end
      SLOT_FULL: begin
        if (i_load) begin
          if (i_ready) w_take = 1'b1;
          else         o_drop = 1'b1;
        end else if (i_ready) begin
          w_next = SLOT_EMPTY;
        end
      end
      default: w_next = SLOT_EMPTY;
    endcase
  end

  assign o_valid = (r_state == SLOT_FULL);
  assign o_data  = r_data;

endmodule

// File: rtl/cpu_oci_dct_packer.sv
// Packs 2-bit DCT codes into a 30-bit shift buffer and emits closed frames.
// Optional macro DCT_TIMESTAMP_EN prefixes each frame with a free-running cycle count.
module cpu_oci_dct_packer
  import cpu_oci_trace_pkg::*;
#(
  parameter int DCT_ENTRIES = DEF_DCT_ENTRIES,
  parameter int CODE_W      = DEF_CODE_W
`ifdef DCT_TIMESTAMP_EN
  , parameter int TS_W      = DEF_TS_W
`endif
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 trace_en,
  input  logic                                 dct_valid,
  input  logic [CODE_W-1:0]                    dct_code,
  input  logic                                 flush_req,
  output logic [DCT_ENTRIES*CODE_W-1:0]        dct_buffer,
  output logic [$clog2(DCT_ENTRIES+1)-1:0]     dct_count,
  cpu_oci_dct_packer_if.master                 frame_if,
  output logic                                 overflow
);

  localparam int BUF_W = DCT_ENTRIES * CODE_W;
  localparam int CNT_W = $clog2(DCT_ENTRIES + 1);
`ifdef DCT_TIMESTAMP_EN
  localparam int FW = TS_W + 2 + CNT_W + BUF_W;
`else
  localparam int FW = 2 + CNT_W + BUF_W;
`endif

  logic [BUF_W-1:0] r_buf;
  logic [CNT_W-1:0] r_cnt;
  logic             r_trace_en_d;
  logic             r_overflow;

  logic             w_insert;
  logic [BUF_W-1:0] w_post_buf;
  logic [CNT_W-1:0] w_post_cnt;
  logic             w_close;
  logic             w_drop;
  logic [FW-1:0]    w_frame;

  // Close is judged on the post-insert view so the inserting code lands in the frame.
  always_comb begin
    w_insert   = trace_en && dct_valid;
    w_post_buf = r_buf;
    w_post_cnt = r_cnt;
    if (w_insert) begin
      w_post_buf = {r_buf[BUF_W-CODE_W-1:0], dct_code};
      w_post_cnt = r_cnt + CNT_W'(1);
    end
    w_close = trace_en &&
              ((w_post_cnt == CNT_W'(DCT_ENTRIES)) || (flush_req && (w_post_cnt != '0)));
  end

  // A disabled trace discards any partial frame rather than emitting it.
  always_ff @(posedge clk) begin
    if (reset || !trace_en || w_close) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else begin
      r_buf <= w_post_buf;
      r_cnt <= w_post_cnt;
    end
  end

`ifdef DCT_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + TS_W'(1);
  end

  assign w_frame = {r_ts, FRAME_TYPE_DCT, w_post_cnt, w_post_buf};
`else
  assign w_frame = {FRAME_TYPE_DCT, w_post_cnt, w_post_buf};
`endif

  cpu_oci_frame_slot #(
    .W (FW)
  ) u_slot (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_close),
    .i_data  (w_frame),
    .i_ready (frame_if.frame_ready),
    .o_valid (frame_if.frame_valid),
    .o_data  (frame_if.frame_data),
    .o_drop  (w_drop)
  );

  // A drop in the re-enable cycle itself still leaves overflow set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_trace_en_d <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_trace_en_d <= trace_en;
      if (w_drop)                         r_overflow <= 1'b1;
      else if (trace_en && !r_trace_en_d) r_overflow <= 1'b0;
    end
  end

  assign dct_buffer = r_buf;
  assign dct_count  = r_cnt;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_cpu_oci_dct_packer.sv
// Self-checking bench for cpu_oci_dct_packer: directed scenarios plus
// randomized traffic against a queue-based frame model.
`timescale 1ns/1ps
module tb_cpu_oci_dct_packer;
  import cpu_oci_trace_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_en;
  logic        dct_valid;
  logic [1:0]  dct_code;
  logic        flush_req;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;

  cpu_oci_dct_packer_if u_if ();

  cpu_oci_dct_packer u_dut (
    .clk        (clk),
    .reset      (reset),
    .trace_en   (trace_en),
    .dct_valid  (dct_valid),
    .dct_code   (dct_code),
    .flush_req  (flush_req),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .frame_if   (u_if),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the frame under construction is just the list of codes seen.
  int          m_codes[$];
  bit          m_full;
  logic [35:0] m_frame;
  bit          m_ovf;
  bit          m_te_prev;

  function automatic logic [29:0] pack_codes();
    logic [29:0] b = '0;
    foreach (m_codes[i]) b = (b << 2) | 30'(m_codes[i]);
    return b;
  endfunction

  task automatic do_reset();
    reset = 1'b1; trace_en = 1'b1; dct_valid = 1'b0; dct_code = 2'b00;
    flush_req = 1'b0; u_if.frame_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_codes.delete(); m_full = 1'b0; m_frame = '0; m_ovf = 1'b0; m_te_prev = 1'b0;
  endtask

  task automatic cycle(input bit te, input bit v, input logic [1:0] c, input bit fl, input bit rdy);
    bit xfer, close, drop;
    int n;
    trace_en = te; dct_valid = v; dct_code = c; flush_req = fl; u_if.frame_ready = rdy;
    xfer = m_full && rdy;
    drop = 1'b0;
    if (te && v) m_codes.push_back(int'(c));
    n = m_codes.size();
    close = te && (n == 15 || (fl && n > 0));
    if (close) begin
      if (m_full && !xfer) drop = 1'b1;
      else begin
        m_full  = 1'b1;
        m_frame = {2'b10, 4'(n), pack_codes()};
      end
    end else if (xfer) begin
      m_full = 1'b0;
    end
    if (!te || close) m_codes.delete();
    if (drop) m_ovf = 1'b1;
    else if (te && !m_te_prev) m_ovf = 1'b0;
    m_te_prev = te;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (dct_buffer !== 30'h0) begin n_bad++; $display("FAIL reset_buffer: got %h expected 0", dct_buffer); end
    n_cmp++; if (dct_count !== 4'h0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", dct_count); end
    n_cmp++; if (u_if.frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", u_if.frame_valid); end
    n_cmp++; if (u_if.frame_data !== 36'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", u_if.frame_data); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_full_frame();
    for (int i = 0; i < 15; i++) begin
      cycle(1'b1, 1'b1, (i % 2 == 0) ? DCT_TAKEN : DCT_NOT_TAKEN, 1'b0, 1'b0);
      if (i == 13) begin
        n_cmp++; if (u_if.frame_valid !== 1'b0) begin n_bad++; $display("FAIL full_early_valid: got %b expected 0", u_if.frame_valid); end
        n_cmp++; if (dct_count !== 4'd14) begin n_bad++; $display("FAIL full_count14: got %0d expected 14", dct_count); end
      end
    end
    n_cmp++; if (u_if.frame_valid !== 1'b1) begin n_bad++; $display("FAIL full_valid: got %b expected 1", u_if.frame_valid); end
    n_cmp++; if (u_if.frame_data !== {2'b10, 4'hF, 30'h11111111}) begin n_bad++; $display("FAIL full_data: got %h expected %h", u_if.frame_data, {2'b10, 4'hF, 30'h11111111}); end
    n_cmp++; if (dct_count !== 4'd0) begin n_bad++; $display("FAIL full_count_clear: got %0d expected 0", dct_count); end
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    n_cmp++; if (u_if.frame_valid !== 1'b0) begin n_bad++; $display("FAIL full_drain: got %b expected 0", u_if.frame_valid); end
  endtask

  task automatic test_flush();
    logic [1:0] codes [3];
    codes[0] = DCT_CALL; codes[1] = DCT_RETURN; codes[2] = DCT_TAKEN;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, codes[i], 1'b0, 1'b0);
      n_cmp++; if (dct_count !== 4'(i + 1)) begin n_bad++; $display("FAIL flush_count: got %0d expected %0d", dct_count, i + 1); end
    end
    cycle(1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    n_cmp++; if (dct_count !== 4'd0) begin n_bad++; $display("FAIL flush_count_clear: got %0d expected 0", dct_count); end
    n_cmp++; if (u_if.frame_data !== {2'b10, 4'h3, 30'h0000002D}) begin n_bad++; $display("FAIL flush_data: got %h expected %h", u_if.frame_data, {2'b10, 4'h3, 30'h0000002D}); end
    n_cmp++; if (u_if.frame_valid !== 1'b1) begin n_bad++; $display("FAIL flush_valid: got %b expected 1", u_if.frame_valid); end
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic test_flush_empty();
    cycle(1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    n_cmp++; if (u_if.frame_valid !== 1'b0) begin n_bad++; $display("FAIL empty_flush_valid: got %b expected 0", u_if.frame_valid); end
    cycle(1'b1, 1'b1, DCT_TAKEN, 1'b1, 1'b0);
    n_cmp++; if (u_if.frame_data !== {2'b10, 4'h1, 30'h1}) begin n_bad++; $display("FAIL flush_insert_data: got %h expected %h", u_if.frame_data, {2'b10, 4'h1, 30'h1}); end
    n_cmp++; if (u_if.frame_valid !== 1'b1) begin n_bad++; $display("FAIL flush_insert_valid: got %b expected 1", u_if.frame_valid); end
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    cycle(1'b1, 1'b1, DCT_CALL, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, DCT_RETURN, 1'b1, 1'b0);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    n_cmp++; if (u_if.frame_data !== {2'b10, 4'h1, 30'h2}) begin n_bad++; $display("FAIL ovf_hold_data: got %h expected %h", u_if.frame_data, {2'b10, 4'h1, 30'h2}); end
    n_cmp++; if (dct_count !== 4'd0) begin n_bad++; $display("FAIL ovf_count: got %0d expected 0", dct_count); end
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    n_cmp++; if (u_if.frame_data !== {2'b10, 4'h1, 30'h2}) begin n_bad++; $display("FAIL ovf_stable: got %h expected %h", u_if.frame_data, {2'b10, 4'h1, 30'h2}); end
    cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    n_cmp++; if (u_if.frame_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_pending: got %b expected 1", u_if.frame_valid); end
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    n_cmp++; if (u_if.frame_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drain: got %b expected 0", u_if.frame_valid); end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 1'b1, DCT_TAKEN, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, DCT_CALL, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, DCT_RETURN, 1'b1, 1'b1);
    n_cmp++; if (u_if.frame_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b expected 1", u_if.frame_valid); end
    n_cmp++; if (u_if.frame_data !== {2'b10, 4'h2, 30'hB}) begin n_bad++; $display("FAIL b2b_data: got %h expected %h", u_if.frame_data, {2'b10, 4'h2, 30'hB}); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic test_trace_disable();
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, DCT_TAKEN, 1'b0, 1'b0);
    n_cmp++; if (dct_count !== 4'd7) begin n_bad++; $display("FAIL dis_count7: got %0d expected 7", dct_count); end
    cycle(1'b0, 1'b1, DCT_RETURN, 1'b1, 1'b0);
    n_cmp++; if (dct_count !== 4'd0) begin n_bad++; $display("FAIL dis_count: got %0d expected 0", dct_count); end
    n_cmp++; if (dct_buffer !== 30'h0) begin n_bad++; $display("FAIL dis_buffer: got %h expected 0", dct_buffer); end
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    n_cmp++; if (u_if.frame_valid !== 1'b0) begin n_bad++; $display("FAIL dis_no_frame: got %b expected 0", u_if.frame_valid); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b1, DCT_TAKEN, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, DCT_CALL, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, DCT_RETURN, 1'b0, 1'b0);
    n_cmp++; if (u_if.frame_valid !== 1'b1 || overflow !== 1'b1) begin n_bad++; $display("FAIL pre_reset: got valid=%b ovf=%b expected 1/1", u_if.frame_valid, overflow); end
    do_reset();
    n_cmp++; if (u_if.frame_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid: got %b expected 0", u_if.frame_valid); end
    n_cmp++; if (u_if.frame_data !== 36'h0) begin n_bad++; $display("FAIL mid_reset_data: got %h expected 0", u_if.frame_data); end
    n_cmp++; if (dct_count !== 4'd0 || dct_buffer !== 30'h0) begin n_bad++; $display("FAIL mid_reset_buf: got cnt=%0d buf=%h expected 0/0", dct_count, dct_buffer); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 24) != 0), ($urandom_range(0, 3) != 0), 2'($urandom),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0));
      n_cmp++; if (dct_count !== 4'(m_codes.size())) begin n_bad++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, dct_count, m_codes.size()); end
      n_cmp++; if (dct_buffer !== pack_codes()) begin n_bad++; $display("FAIL rnd_buffer[%0d]: got %h expected %h", i, dct_buffer, pack_codes()); end
      n_cmp++; if (u_if.frame_valid !== m_full) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, u_if.frame_valid, m_full); end
      n_cmp++; if (u_if.frame_data[35:0] !== m_frame) begin n_bad++; $display("FAIL rnd_data[%0d]: got %h expected %h", i, u_if.frame_data[35:0], m_frame); end
      n_cmp++; if (overflow !== m_ovf) begin n_bad++; $display("FAIL rnd_overflow[%0d]: got %b expected %b", i, overflow, m_ovf); end
    end
  endtask

  initial begin
    reset = 1'b1; trace_en = 1'b0; dct_valid = 1'b0; dct_code = 2'b00;
    flush_req = 1'b0; u_if.frame_ready = 1'b0;
    test_reset();
    test_full_frame();
    test_flush();
    test_flush_empty();
    test_overflow();
    test_back_to_back();
    test_trace_disable();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
